// File: rtl/cc_input_ctrl.sv
// cc_input_ctrl: input conditioning for the crazy_climber core.
// Decodes PS/2 key events, merges them with both joysticks into the
// two-stick control set, and turns start/coin requests into a timed
// coin pulse. Start stays masked until the coin has been credited.
module cc_input_ctrl #(
    parameter int             CW       = 24,
    parameter logic [CW-1:0]  COIN_LEN = 24'd1200000,
    parameter logic [CW-1:0]  COIN_GAP = 24'd1200000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    output logic        l_up,
    output logic        l_down,
    output logic        l_left,
    output logic        l_right,
    output logic        r_up,
    output logic        r_down,
    output logic        r_left,
    output logic        r_right,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COIN = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LEN_LAST = COIN_LEN - CW'(1);
    localparam logic [CW-1:0] GAP_LAST = COIN_GAP - CW'(1);

    // Key event tracking
    logic old_tog;
    logic primed;
    logic key_event;

    // Keyboard latches
    logic kb_lu, kb_ld, kb_ll, kb_lr;
    logic kb_ru, kb_rd, kb_rl, kb_rr;
    logic kb_s1, kb_s2, kb_coin;

    // Merged joystick and request terms
    logic [15:0] j;
    logic        req_s1;
    logic        req_s2;
    logic        req_any;
    logic        req_q;
    logic        trig;
    logic        unused_joy;

    state_t        state;
    logic [CW-1:0] cnt;

    // The first cycle after reset only samples the toggle bit, so a toggle
    // level left over from before reset is never mistaken for a new event.
    assign key_event  = primed & (old_tog ^ ps2_key[10]);

    assign j          = joystick_0 | joystick_1;
    assign req_s1     = kb_s1 | j[8];
    assign req_s2     = kb_s2 | j[9];
    assign req_any    = req_s1 | req_s2 | kb_coin | j[10];
    assign trig       = req_any & ~req_q;
    assign unused_joy = ^j[15:11];

    // Track the PS/2 toggle bit and latch pressed/released state per key
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            old_tog <= 1'b0;
            primed  <= 1'b0;
            kb_lu   <= 1'b0;
            kb_ld   <= 1'b0;
            kb_ll   <= 1'b0;
            kb_lr   <= 1'b0;
            kb_ru   <= 1'b0;
            kb_rd   <= 1'b0;
            kb_rl   <= 1'b0;
            kb_rr   <= 1'b0;
            kb_s1   <= 1'b0;
            kb_s2   <= 1'b0;
            kb_coin <= 1'b0;
        end else begin
            old_tog <= ps2_key[10];
            primed  <= 1'b1;
            if (key_event) begin
                case (ps2_key[7:0])
                    8'h75: kb_ru <= ps2_key[9];
                    8'h72: kb_rd <= ps2_key[9];
                    8'h6B: kb_rl <= ps2_key[9];
                    8'h74: kb_rr <= ps2_key[9];
                    8'h1D: kb_lu <= ps2_key[9];
                    8'h1C: kb_ll <= ps2_key[9];
                    8'h1B: kb_ld <= ps2_key[9];
                    8'h23: kb_lr <= ps2_key[9];
                    // F-keys share codes with extended keys, so bit 8 must be clear
                    8'h05: if (!ps2_key[8]) kb_s1   <= ps2_key[9];
                    8'h06: if (!ps2_key[8]) kb_s2   <= ps2_key[9];
                    8'h04: if (!ps2_key[8]) kb_coin <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    // Register the merged stick outputs; sticks are never masked
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            l_up    <= 1'b0;
            l_down  <= 1'b0;
            l_left  <= 1'b0;
            l_right <= 1'b0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_left  <= 1'b0;
            r_right <= 1'b0;
        end else begin
            l_right <= kb_lr | j[0];
            l_left  <= kb_ll | j[1];
            l_down  <= kb_ld | j[2];
            l_up    <= kb_lu | j[3];
            r_right <= kb_rr | j[4];
            r_left  <= kb_rl | j[5];
            r_down  <= kb_rd | j[6];
            r_up    <= kb_ru | j[7];
        end
    end

    // Registered copy of the combined request for rising-edge detection
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_any;
        end
    end

    // Coin sequencer: pulse coin1 for COIN_LEN cycles, hold a quiet gap,
    // then let start through. Triggers outside IDLE are dropped.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            coin1  <= 1'b0;
            start1 <= 1'b0;
            start2 <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (trig) begin
                        state  <= COIN;
                        coin1  <= 1'b1;
                        start1 <= 1'b0;
                        start2 <= 1'b0;
                        busy   <= 1'b1;
                    end else begin
                        coin1  <= 1'b0;
                        start1 <= req_s1;
                        start2 <= req_s2;
                        busy   <= 1'b0;
                    end
                end
                COIN: begin
                    start1 <= 1'b0;
                    start2 <= 1'b0;
                    busy   <= 1'b1;
                    if (cnt == LEN_LAST) begin
                        state <= GAP;
                        coin1 <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        coin1 <= 1'b1;
                        cnt   <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    coin1  <= 1'b0;
                    start1 <= 1'b0;
                    start2 <= 1'b0;
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    coin1  <= 1'b0;
                    start1 <= 1'b0;
                    start2 <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cc_input_ctrl.sv
// tb_cc_input_ctrl: directed, table-driven checks of cc_input_ctrl with
// short coin timing (COIN_LEN=4, COIN_GAP=3).
module tb_cc_input_ctrl;

    logic        clk_sys;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        l_up, l_down, l_left, l_right;
    logic        r_up, r_down, r_left, r_right;
    logic        start1, start2, coin1, busy;

    int n_checks;
    int n_fail;

    cc_input_ctrl #(
        .CW       (24),
        .COIN_LEN (24'd4),
        .COIN_GAP (24'd3)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .joystick_0 (joystick_0),
        .joystick_1 (joystick_1),
        .l_up       (l_up),
        .l_down     (l_down),
        .l_left     (l_left),
        .l_right    (l_right),
        .r_up       (r_up),
        .r_down     (r_down),
        .r_left     (r_left),
        .r_right    (r_right),
        .start1     (start1),
        .start2     (start2),
        .coin1      (coin1),
        .busy       (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [15:0] j0;
        logic [15:0] j1;
        logic [7:0]  exp_sticks; // {lu, ld, ll, lr, ru, rd, rl, rr}
    } vec_t;

    vec_t vecs[6];

    function automatic logic [7:0] sticks();
        return {l_up, l_down, l_left, l_right, r_up, r_down, r_left, r_right};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Send one PS/2 event and give it time to reach the stick registers
    task automatic key(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
        step();
        step();
    endtask

    initial begin
        int coin_cycles;
        int coin_edges;
        logic prev_coin;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{16'h0001, 16'h0000, 8'h10};
        vecs[1] = '{16'h0000, 16'h0008, 8'h80};
        vecs[2] = '{16'h0010, 16'h0080, 8'h09};
        vecs[3] = '{16'h0066, 16'h0000, 8'h66};
        vecs[4] = '{16'h00FF, 16'h00FF, 8'hFF};
        vecs[5] = '{16'h0000, 16'h0000, 8'h00};

        // Reset with a pending-looking key code on the bus
        reset      = 1'b1;
        joystick_0 = 16'h0000;
        joystick_1 = 16'h0000;
        ps2_key    = {1'b1, 1'b1, 9'h075};
        step();
        step();
        chk("reset_sticks", {24'd0, sticks()}, 32'h0);
        chk("reset_ctrl", {28'd0, start1, start2, coin1, busy}, 32'h0);

        // Priming: the held toggle level must not decode as an event
        reset = 1'b0;
        step();
        step();
        step();
        chk("prime_no_decode", {31'd0, r_up}, 32'd1 - 32'd1);

        // Key path
        key(1'b1, 9'h075);
        chk("key_ru_press", {24'd0, sticks()}, 32'h08);
        key(1'b0, 9'h175);
        chk("key_ru_ext_release", {24'd0, sticks()}, 32'h00);
        key(1'b1, 9'h01D);
        chk("key_lu_press", {24'd0, sticks()}, 32'h80);
        key(1'b1, 9'h023);
        chk("key_lu_lr", {24'd0, sticks()}, 32'h90);
        key(1'b0, 9'h01D);
        key(1'b0, 9'h023);
        key(1'b1, 9'h0FF);
        chk("key_unknown", {24'd0, sticks()}, 32'h00);
        key(1'b1, 9'h105);
        step();
        chk("key_ext_f1_ignored", {30'd0, coin1, busy}, 32'h0);
        key(1'b0, 9'h105);

        // Joystick merge table
        for (int i = 0; i < 6; i++) begin
            joystick_0 = vecs[i].j0;
            joystick_1 = vecs[i].j1;
            step();
            chk($sformatf("merge_%0d", i), {24'd0, sticks()}, {24'd0, vecs[i].exp_sticks});
        end

        // Coin timing with start1 held on joystick_1
        joystick_1 = 16'h0100;
        for (int n = 1; n <= 11; n++) begin
            step();
            chk($sformatf("coin_t%0d", n), {31'd0, coin1}, ((n >= 1) && (n <= 4)) ? 32'd1 : 32'd0);
            chk($sformatf("busy_t%0d", n), {31'd0, busy}, ((n >= 1) && (n <= 7)) ? 32'd1 : 32'd0);
            chk($sformatf("start1_t%0d", n), {31'd0, start1}, (n >= 9) ? 32'd1 : 32'd0);
        end
        joystick_1 = 16'h0000;
        step();
        step();
        chk("start1_release", {31'd0, start1}, 32'd0);

        // Retrigger attempts during COIN are ignored
        coin_cycles = 0;
        coin_edges  = 0;
        prev_coin   = 1'b0;
        joystick_0  = 16'h0400;
        for (int n = 1; n <= 16; n++) begin
            step();
            if (coin1) coin_cycles++;
            if (coin1 && !prev_coin) coin_edges++;
            prev_coin = coin1;
            if (n == 2) begin
                joystick_0 = 16'h0000;
                ps2_key    = {~ps2_key[10], 1'b1, 9'h004};
            end
            if (n == 3) joystick_0 = 16'h0400;
            if (n == 4) joystick_0 = 16'h0000;
            if (n == 5) ps2_key = {~ps2_key[10], 1'b0, 9'h004};
        end
        chk("retrig_len", coin_cycles, 32'd4);
        chk("retrig_pulses", coin_edges, 32'd1);
        chk("retrig_idle", {30'd0, coin1, busy}, 32'h0);

        // Simultaneous starts from keyboard F1 and joystick Start2
        coin_edges = 0;
        prev_coin  = 1'b0;
        ps2_key    = {~ps2_key[10], 1'b1, 9'h005};
        joystick_0 = 16'h0200;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (coin1 && !prev_coin) coin_edges++;
            prev_coin = coin1;
        end
        chk("dual_one_coin", coin_edges, 32'd1);
        chk("dual_starts", {30'd0, start1, start2}, 32'h3);
        ps2_key    = {~ps2_key[10], 1'b0, 9'h005};
        joystick_0 = 16'h0000;
        step();
        step();
        chk("dual_release", {30'd0, start1, start2}, 32'h0);

        // Async reset in the middle of COIN
        joystick_0 = 16'h0400;
        step();
        step();
        step();
        chk("pre_reset_coin", {30'd0, coin1, busy}, 32'h3);
        reset = 1'b1;
        #1;
        chk("async_reset_drop", {30'd0, coin1, busy}, 32'h0);
        joystick_0 = 16'h0000;
        step();
        reset = 1'b0;
        step();
        step();
        chk("post_reset_idle", {30'd0, coin1, busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
